// File: rtl/universal_shift_reg.sv
// N-bit register with parallel load and multi-cycle shift/rotate.
// Start launches an operation; Busy covers the shift cycles, Done pulses once.
module universal_shift_reg #(
    parameter int                 WIDTH       = 8,
    parameter int                 AW          = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Mode,
    input  logic [AW-1:0]    Amount,
    input  logic [WIDTH-1:0] D,
    input  logic             Ser_in,
    output logic [WIDTH-1:0] Q,
    output logic             Ser_out,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_SHR  = 3'd3;
    localparam logic [2:0] M_ASR  = 3'd4;
    localparam logic [2:0] M_ROL  = 3'd5;
    localparam logic [2:0] M_ROR  = 3'd6;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sh_q;
    logic             sh_so;
    logic             is_shift;

    // One single-bit step of the captured mode.
    always_comb begin
        sh_q  = q_q;
        sh_so = so_q;
        case (mode_q)
            M_SHL: begin
                sh_q  = {q_q[WIDTH-2:0], Ser_in};
                sh_so = q_q[WIDTH-1];
            end
            M_SHR: begin
                sh_q  = {Ser_in, q_q[WIDTH-1:1]};
                sh_so = q_q[0];
            end
            M_ASR: begin
                sh_q  = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                sh_so = q_q[0];
            end
            M_ROL: begin
                sh_q  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                sh_so = q_q[WIDTH-1];
            end
            M_ROR: begin
                sh_q  = {q_q[0], q_q[WIDTH-1:1]};
                sh_so = q_q[0];
            end
            default: ;
        endcase
    end

    assign is_shift = (Mode >= M_SHL) && (Mode <= M_ROR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        so_d    = so_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (is_shift && (Amount != '0)) begin
                        mode_d  = Mode;
                        cnt_d   = Amount;
                        state_d = SHIFT;
                    end else begin
                        done_d = 1'b1;
                        if (Mode == M_LOAD) begin
                            q_d = D;
                        end
                    end
                end
            end
            SHIFT: begin
                q_d   = sh_q;
                so_d  = sh_so;
                cnt_d = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            q_q     <= RESET_VALUE;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign Q       = q_q;
    assign Ser_out = so_q;
    assign Busy    = (state_q == SHIFT);
    assign Done    = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: scenario tasks plus a Done-driven
// scoreboard that compares final Q/Ser_out against a behavioural model.
module tb_universal_shift_reg;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [2:0] Mode = 3'd0;
    logic [3:0] Amount = 4'd0;
    logic [7:0] D = 8'h00;
    logic       Ser_in = 1'b0;
    logic [7:0] Q;
    logic       Ser_out;
    logic       Busy;
    logic       Done;

    typedef struct packed {
        logic [7:0] q;
        logic       so;
    } exp_t;

    exp_t sb[$];
    exp_t cur = '{8'h00, 1'b0};
    int   total = 0;
    int   passed = 0;

    universal_shift_reg #(
        .WIDTH(8),
        .AW(4),
        .RESET_VALUE(8'h00)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .Mode(Mode),
        .Amount(Amount),
        .D(D),
        .Ser_in(Ser_in),
        .Q(Q),
        .Ser_out(Ser_out),
        .Busy(Busy),
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(exp_t s, logic [2:0] m, int k,
                                   logic [7:0] d, logic si);
        exp_t r = s;
        if (m == 3'd1) r.q = d;
        else if (m >= 3'd2 && m <= 3'd6) begin
            for (int i = 0; i < k; i++) begin
                case (m)
                    3'd2: begin r.so = r.q[7]; r.q = {r.q[6:0], si}; end
                    3'd3: begin r.so = r.q[0]; r.q = {si, r.q[7:1]}; end
                    3'd4: begin r.so = r.q[0]; r.q = {r.q[7], r.q[7:1]}; end
                    3'd5: begin r.so = r.q[7]; r.q = {r.q[6:0], r.q[7]}; end
                    default: begin r.so = r.q[0]; r.q = {r.q[0], r.q[7:1]}; end
                endcase
            end
        end
        return r;
    endfunction

    // Scoreboard: every Done pops the oldest expected result.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset === 1'b0 && Done === 1'b1) begin
            total++;
            if (sb.size() == 0)
                $display("FAIL sb_unexpected_done Q=%h so=%b", Q, Ser_out);
            else begin
                e = sb.pop_front();
                if ({Q, Ser_out} !== e)
                    $display("FAIL sb_result got Q=%h so=%b exp Q=%h so=%b",
                             Q, Ser_out, e.q, e.so);
                else passed++;
            end
        end
    end

    task automatic issue(input logic [2:0] m, input int k,
                         input logic [7:0] d, input bit push);
        Mode = m;
        Amount = 4'(k);
        D = d;
        Start = 1'b1;
        if (push) begin
            cur = model(cur, m, k, d, Ser_in);
            sb.push_back(cur);
        end
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n,
                             output int busy_n, output bit ok);
        ok = 1'b0;
        n = 0;
        busy_n = 0;
        for (int i = 0; i <= budget; i++) begin
            if (Done === 1'b1) begin
                ok = 1'b1;
                n = i;
                return;
            end
            if (Busy === 1'b1) busy_n++;
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if (Q !== 8'h00) $display("FAIL reset_q got=%h exp=00", Q);
        else passed++;
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0)
            $display("FAIL reset_flags got busy=%b done=%b exp 0 0", Busy, Done);
        else passed++;
        total++;
        if (Ser_out !== 1'b0) $display("FAIL reset_so got=%b exp=0", Ser_out);
        else passed++;
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_load();
        issue(3'd1, 0, 8'hA5, 1'b1);
        total++;
        if (Q !== 8'hA5 || Done !== 1'b1 || Busy !== 1'b0)
            $display("FAIL load got Q=%h done=%b busy=%b exp A5 1 0", Q, Done, Busy);
        else passed++;
        @(negedge Clk);
        total++;
        if (Done !== 1'b0 || Busy !== 1'b0)
            $display("FAIL load_pulse got done=%b busy=%b exp 0 0", Done, Busy);
        else passed++;
    endtask

    task automatic test_shl();
        logic [7:0] seq[3] = '{8'h4B, 8'h97, 8'h2F};
        logic       sos[3] = '{1'b1, 1'b0, 1'b1};
        Ser_in = 1'b1;
        issue(3'd2, 3, 8'h00, 1'b1);
        total++;
        if (Busy !== 1'b1 || Q !== 8'hA5)
            $display("FAIL shl_start got busy=%b Q=%h exp 1 A5", Busy, Q);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            total++;
            if (Q !== seq[i] || Ser_out !== sos[i])
                $display("FAIL shl_step%0d got Q=%h so=%b exp Q=%h so=%b",
                         i, Q, Ser_out, seq[i], sos[i]);
            else passed++;
            total++;
            if (Busy !== (i < 2) || Done !== (i == 2))
                $display("FAIL shl_flags%0d got busy=%b done=%b exp %b %b",
                         i, Busy, Done, i < 2, i == 2);
            else passed++;
        end
        @(negedge Clk);
        total++;
        if (Done !== 1'b0) $display("FAIL shl_pulse got done=%b exp=0", Done);
        else passed++;
    endtask

    task automatic test_asr_ror();
        int  n, b;
        bit  ok;
        issue(3'd1, 0, 8'h90, 1'b1);
        issue(3'd4, 2, 8'h00, 1'b1);
        wait_done(20, n, b, ok);
        total++;
        if (!ok || n != 2 || Q !== 8'hE4)
            $display("FAIL asr got ok=%b lat=%0d Q=%h exp 1 2 E4", ok, n, Q);
        else passed++;
        issue(3'd6, 9, 8'h00, 1'b1);
        wait_done(20, n, b, ok);
        total++;
        if (!ok || n != 9 || b != 9 || Q !== 8'h72)
            $display("FAIL ror9 got ok=%b lat=%0d busy=%0d Q=%h exp 1 9 9 72",
                     ok, n, b, Q);
        else passed++;
    endtask

    task automatic test_amount0();
        issue(3'd3, 0, 8'h00, 1'b1);
        total++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Q !== 8'h72)
            $display("FAIL amt0 got done=%b busy=%b Q=%h exp 1 0 72", Done, Busy, Q);
        else passed++;
        @(negedge Clk);
        total++;
        if (Done !== 1'b0 || Busy !== 1'b0)
            $display("FAIL amt0_pulse got done=%b busy=%b exp 0 0", Done, Busy);
        else passed++;
    endtask

    task automatic test_ignored_start();
        int n, b;
        bit ok;
        issue(3'd5, 5, 8'h00, 1'b1);
        Mode = 3'd1;
        D = 8'hFF;
        Amount = 4'd0;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        Mode = 3'd0;
        wait_done(20, n, b, ok);
        total++;
        if (!ok || n != 4 || Q !== 8'h4E)
            $display("FAIL rol5_ignore got ok=%b lat=%0d Q=%h exp 1 4 4E", ok, n, Q);
        else passed++;
        @(negedge Clk);
        total++;
        if (Q !== 8'h4E || Busy !== 1'b0)
            $display("FAIL rol5_after got Q=%h busy=%b exp 4E 0", Q, Busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int dn = 0, bn = 0;
        Ser_in = 1'b0;
        issue(3'd3, 6, 8'h00, 1'b0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        total++;
        if (Q !== 8'h00 || Busy !== 1'b0 || Done !== 1'b0)
            $display("FAIL reset_mid got Q=%h busy=%b done=%b exp 00 0 0",
                     Q, Busy, Done);
        else passed++;
        Reset = 1'b0;
        cur = '{8'h00, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (Done === 1'b1) dn++;
            if (Busy === 1'b1) bn++;
        end
        total++;
        if (dn != 0 || bn != 0)
            $display("FAIL reset_mid_quiet got done=%0d busy=%0d exp 0 0", dn, bn);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exq[4] = '{8'h03, 8'h06, 8'h0C, 8'h18};
        issue(3'd1, 0, 8'h81, 1'b1);
        Mode = 3'd5;
        Amount = 4'd1;
        Start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur = model(cur, 3'd5, 1, 8'h00, Ser_in);
            sb.push_back(cur);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            total++;
            if (Busy !== 1'b1 || Done !== 1'b0)
                $display("FAIL b2b_busy%0d got busy=%b done=%b exp 1 0", i, Busy, Done);
            else passed++;
            @(negedge Clk);
            total++;
            if (Done !== 1'b1 || Busy !== 1'b0 || Q !== exq[i])
                $display("FAIL b2b_done%0d got done=%b busy=%b Q=%h exp 1 0 %h",
                         i, Done, Busy, Q, exq[i]);
            else passed++;
            if (i == 3) Start = 1'b0;
        end
        @(negedge Clk);
        total++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Q !== 8'h18)
            $display("FAIL b2b_end got busy=%b done=%b Q=%h exp 0 0 18", Busy, Done, Q);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_asr_ror();
        test_amount0();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge Clk);
        total++;
        if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
